// File: rtl/spi_flash_pkg.sv
// Shared state encoding and protocol constants for the SPI flash reader.
// SPI_FLASH_FAST_READ_EN selects FAST_READ (0x0B plus 8 dummy clocks) instead of READ (0x03).
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned ADDR_BITS  = 24;
    localparam int unsigned DUMMY_BITS = 8;
    localparam int unsigned DATA_BITS  = 32;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] CMD_ACTIVE = CMD_FAST_READ;
`else
    localparam logic [7:0] CMD_ACTIVE = CMD_READ;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_CMD,
        SHIFT_ADDR,
        SHIFT_DATA,
        GAP
`ifdef SPI_FLASH_FAST_READ_EN
        , DUMMY
`endif
    } state_e;

    // Terminal value of a per-phase bit counter for a phase of n bits.
    function automatic logic [4:0] last_bit(input int unsigned n);
        return 5'(n - 1);
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator: divides the system clock into SCK half-periods of CLK_DIV cycles
// and flags the cycle before each SCK rising/falling transition. Held low while disabled.
module spi_sck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       sck_q, sck_d;
    logic       half_done;

    assign half_done = en_i && (cnt_q == 8'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!en_i) begin
            cnt_d = 8'd0;
            sck_d = 1'b0;
        end else if (half_done) begin
            cnt_d = 8'd0;
            sck_d = ~sck_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o  = sck_q;
    assign rise_o = half_done && !sck_q;
    assign fall_o = half_done && sck_q;

endmodule

// File: rtl/spi_flash_reader.sv
// Single-bit SPI (mode 0) flash read initiator returning one little-endian 32-bit word per request.
// SPI_FLASH_FAST_READ_EN switches to FAST_READ with an 8-clock dummy phase.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_IDLE = 4
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    state_e      state_q;
    logic [31:0] tx_q;
    logic [31:0] rx_q;
    logic [31:0] rsp_data_q;
    logic [4:0]  bit_cnt_q;
    logic [7:0]  gap_cnt_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        busy_q;
    logic        csb_q;
    logic        io0_q;
`ifdef SPI_FLASH_FAST_READ_EN
    logic [2:0]  dummy_cnt_q;
`endif

    logic        sck_rise;
    logic        sck_fall;
    logic [4:0]  rx_idx;

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk_i (clock),
        .rst_ni(resetb),
        .en_i  (~csb_q),
        .sck_o (flash_clk),
        .rise_o(sck_rise),
        .fall_o(sck_fall)
    );

    // Bytes arrive in order into ascending lanes, each byte MSB first.
    assign rx_idx = {bit_cnt_q[4:3], ~bit_cnt_q[2:0]};

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            csb_q       <= 1'b1;
            io0_q       <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
            dummy_cnt_q <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        state_q     <= SHIFT_CMD;
                        tx_q        <= {CMD_ACTIVE, req_addr};
                        io0_q       <= CMD_ACTIVE[7];
                        csb_q       <= 1'b0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        bit_cnt_q   <= '0;
                    end
                end
                SHIFT_CMD: begin
                    if (sck_fall) begin
                        tx_q  <= {tx_q[30:0], 1'b0};
                        io0_q <= tx_q[30];
                        if (bit_cnt_q == last_bit(CMD_BITS)) begin
                            state_q   <= SHIFT_ADDR;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                SHIFT_ADDR: begin
                    if (sck_fall) begin
                        if (bit_cnt_q == last_bit(ADDR_BITS)) begin
                            io0_q     <= 1'b0;
                            bit_cnt_q <= '0;
`ifdef SPI_FLASH_FAST_READ_EN
                            state_q     <= DUMMY;
                            dummy_cnt_q <= '0;
`else
                            state_q   <= SHIFT_DATA;
`endif
                        end else begin
                            tx_q      <= {tx_q[30:0], 1'b0};
                            io0_q     <= tx_q[30];
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
`ifdef SPI_FLASH_FAST_READ_EN
                DUMMY: begin
                    if (sck_fall) begin
                        if (dummy_cnt_q == 3'(DUMMY_BITS - 1)) begin
                            state_q <= SHIFT_DATA;
                        end else begin
                            dummy_cnt_q <= dummy_cnt_q + 3'd1;
                        end
                    end
                end
`endif
                SHIFT_DATA: begin
                    if (sck_rise) begin
                        rx_q[rx_idx] <= flash_io1;
                    end
                    // The response goes out on the edge that returns SCK low after the last bit.
                    if (sck_fall) begin
                        if (bit_cnt_q == last_bit(DATA_BITS)) begin
                            state_q     <= GAP;
                            csb_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rx_q;
                            gap_cnt_q   <= 8'(CS_IDLE);
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                GAP: begin
                    // CS_IDLE cycles follow the response cycle before a new request is taken.
                    if (gap_cnt_q == 8'd0) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    csb_q       <= 1'b1;
                    io0_q       <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign flash_csb = csb_q;
    assign flash_io0 = io0_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=2 and 1) each wired to a behavioural flash.
// Build with SPI_FLASH_FAST_READ_EN defined to exercise the FAST_READ variant.
module tb_spi_flash_reader;

    localparam int CS_IDLE = 4;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam int DUMMY = 8;
    localparam logic [7:0] EXP_CMD = 8'h0B;
`else
    localparam int DUMMY = 0;
    localparam logic [7:0] EXP_CMD = 8'h03;
`endif
    localparam int NBITS = 64 + DUMMY;

    logic clock  = 1'b0;
    logic resetb = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready, rsp_valid, busy, flash_csb, flash_clk, flash_io0;
    logic [23:0] req_addr [2];
    logic [31:0] rsp_data [2];
    logic [7:0]  mem [512];

    function automatic logic fm_data_bit(input logic [23:0] base, input int j);
        logic [7:0] b;
        b = mem[9'(base + 24'(j / 8))];
        return b[7 - (j % 8)];
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int unsigned D = (gi == 0) ? 2 : 1;
        logic        io1    = 1'b0;
        int          fm_cnt = 0;
        int          fm_last = 0;
        logic [30:0] fm_sr  = '0;
        logic [7:0]  fm_cmd = '0;
        logic [23:0] fm_addr = '0;
        int          m0_viol = 0;
        logic        p_sck = 1'b0;
        logic        p_io0 = 1'b0;

        spi_flash_reader #(
            .CLK_DIV(D),
            .CS_IDLE(CS_IDLE)
        ) u_dut (
            .clock    (clock),
            .resetb   (resetb),
            .req_valid(req_valid[gi]),
            .req_ready(req_ready[gi]),
            .req_addr (req_addr[gi]),
            .rsp_valid(rsp_valid[gi]),
            .rsp_data (rsp_data[gi]),
            .busy     (busy[gi]),
            .flash_csb(flash_csb[gi]),
            .flash_clk(flash_clk[gi]),
            .flash_io0(flash_io0[gi]),
            .flash_io1(io1)
        );

        // Flash: capture command/address on SCK rise, drive data on SCK fall.
        always @(posedge flash_clk[gi] or posedge flash_csb[gi]) begin
            if (flash_csb[gi]) begin
                fm_last <= fm_cnt;
                fm_cnt  <= 0;
            end else begin
                fm_sr  <= {fm_sr[29:0], flash_io0[gi]};
                fm_cnt <= fm_cnt + 1;
                if (fm_cnt == 31) begin
                    fm_cmd  <= fm_sr[30:23];
                    fm_addr <= {fm_sr[22:0], flash_io0[gi]};
                end
            end
        end

        always @(negedge flash_clk[gi]) begin
            if (!flash_csb[gi] && fm_cnt >= 32 + DUMMY && fm_cnt < 64 + DUMMY)
                io1 <= fm_data_bit(fm_addr, fm_cnt - 32 - DUMMY);
        end

        // Mode-0 monitor: io0 steady while SCK high, SCK low whenever CSB high.
        always @(negedge clock) begin
            if ((p_sck && flash_clk[gi] && (flash_io0[gi] !== p_io0)) ||
                (flash_csb[gi] && flash_clk[gi]))
                m0_viol <= m0_viol + 1;
            p_sck <= flash_clk[gi];
            p_io0 <= flash_io0[gi];
        end
    end

    function automatic int clk_div(input int inst);
        return (inst == 0) ? 2 : 1;
    endfunction
    function automatic logic [7:0] get_cmd(input int inst);
        return (inst == 0) ? g_inst[0].fm_cmd : g_inst[1].fm_cmd;
    endfunction
    function automatic logic [23:0] get_addr(input int inst);
        return (inst == 0) ? g_inst[0].fm_addr : g_inst[1].fm_addr;
    endfunction
    function automatic int get_last(input int inst);
        return (inst == 0) ? g_inst[0].fm_last : g_inst[1].fm_last;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issues one request; lat = cycles from the accept cycle to the rsp_valid cycle (-1 on timeout).
    task automatic do_read(input int inst, input logic [23:0] addr,
                           output logic [31:0] data, output int lat);
        int t0;
        int k;
        lat  = -1;
        data = '0;
        @(negedge clock);
        k = 0;
        while (!req_ready[inst] && k < 2000) begin
            @(negedge clock);
            k++;
        end
        req_valid[inst] = 1'b1;
        req_addr[inst]  = addr;
        t0 = cyc;
        @(posedge clock);
        #1;
        req_valid[inst] = 1'b0;
        req_addr[inst]  = 24'hABCDEF;
        k = 0;
        while (k < 2000) begin
            @(negedge clock);
            if (rsp_valid[inst]) break;
            k++;
        end
        if (rsp_valid[inst]) begin
            lat  = cyc - t0;
            data = rsp_data[inst];
        end
    endtask

    typedef struct {
        int          inst;
        logic [23:0] addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] data;
        int          lat;
        int          exp_lat;
        int          a1, a2, r1, k, ready_hi, csb_hi, saw_rsp;

        vecs[0] = '{0, 24'h000000, 32'h3412D500};
        vecs[1] = '{1, 24'h000101, 32'h7EC35BA1};
        vecs[2] = '{0, 24'hFFFFFC, 32'h44332211};
        vecs[3] = '{1, 24'h000002, 32'h09E73412};

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[9'h000] = 8'h00; mem[9'h001] = 8'hD5; mem[9'h002] = 8'h12; mem[9'h003] = 8'h34;
        mem[9'h004] = 8'hE7; mem[9'h005] = 8'h09;
        mem[9'h101] = 8'hA1; mem[9'h102] = 8'h5B; mem[9'h103] = 8'hC3; mem[9'h104] = 8'h7E;
        mem[9'h1FC] = 8'h11; mem[9'h1FD] = 8'h22; mem[9'h1FE] = 8'h33; mem[9'h1FF] = 8'h44;
        req_addr[0] = '0;
        req_addr[1] = '0;

        // Asynchronous reset applied between clock edges.
        #1 resetb = 1'b0;
        #2;
        chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_rsp_data",  rsp_data[0], 32'h0);
        chk("rst_busy",      32'(busy[0]), 32'd0);
        chk("rst_csb",       32'(flash_csb[0]), 32'd1);
        chk("rst_sck",       32'(flash_clk[0]), 32'd0);
        chk("rst_io0",       32'(flash_io0[0]), 32'd0);
        chk("rst_csb_i1",    32'(flash_csb[1]), 32'd1);
        repeat (3) @(negedge clock);
        resetb = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 4; i++) begin
            exp_lat = 1 + NBITS * 2 * clk_div(vecs[i].inst);
            do_read(vecs[i].inst, vecs[i].addr, data, lat);
            $display("txn %0d: inst=%0d addr=0x%06h data=0x%08h latency=%0d",
                     i, vecs[i].inst, vecs[i].addr, data, lat);
            chk($sformatf("v%0d_data", i), data, vecs[i].exp_data);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
            chk($sformatf("v%0d_cmd", i), 32'(get_cmd(vecs[i].inst)), 32'(EXP_CMD));
            chk($sformatf("v%0d_addr", i), 32'(get_addr(vecs[i].inst)), 32'(vecs[i].addr));
            @(negedge clock);
            chk($sformatf("v%0d_rsp_pulse", i), 32'(rsp_valid[vecs[i].inst]), 32'd0);
            chk($sformatf("v%0d_rsp_hold", i), rsp_data[vecs[i].inst], vecs[i].exp_data);
            chk($sformatf("v%0d_sck_count", i), 32'(get_last(vecs[i].inst)), 32'(NBITS));
        end

        // Back-to-back: req_valid held high across the whole first transfer.
        @(negedge clock);
        while (!req_ready[0]) @(negedge clock);
        req_valid[0] = 1'b1;
        req_addr[0]  = 24'h000000;
        a1 = cyc;
        ready_hi = 0;
        r1 = -1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clock);
            if (rsp_valid[0]) begin
                r1 = cyc;
                break;
            end
            if (req_ready[0]) ready_hi++;
        end
        $display("txn b2b-1: accept=%0d rsp=%0d data=0x%08h", a1, r1, rsp_data[0]);
        chk("b2b_first_latency", 32'(r1 - a1), 32'(1 + NBITS * 4));
        chk("b2b_ready_low", 32'(ready_hi), 32'd0);
        @(negedge clock);
        chk("b2b_gap_busy", 32'(busy[0]), 32'd1);
        csb_hi = (flash_csb[0] === 1'b1) ? 1 : 0;  // already high in the rsp_valid cycle
        a2 = -1;
        for (int n = 0; n < 50; n++) begin
            if (flash_csb[0]) csb_hi++;
            if (req_ready[0]) begin
                a2 = cyc;
                break;
            end
            @(negedge clock);
        end
        chk("b2b_accept_gap", 32'(a2 - r1), 32'(CS_IDLE + 1));
        chk("b2b_csb_high_ge", 32'(csb_hi >= CS_IDLE), 32'd1);
        @(posedge clock);
        #1;
        req_valid[0] = 1'b0;
        k = 0;
        while (!rsp_valid[0] && k < 2000) begin
            @(negedge clock);
            k++;
        end
        $display("txn b2b-2: accept=%0d rsp=%0d data=0x%08h", a2, cyc, rsp_data[0]);
        chk("b2b_second_latency", 32'(cyc - a2), 32'(1 + NBITS * 4));
        chk("b2b_second_data", rsp_data[0], 32'h3412D500);

        // Reset during address bit 10 of a read.
        @(negedge clock);
        while (!req_ready[0]) @(negedge clock);
        req_valid[0] = 1'b1;
        req_addr[0]  = 24'h000101;
        @(posedge clock);
        #1;
        req_valid[0] = 1'b0;
        k = 0;
        while (g_inst[0].fm_cnt < 19 && k < 500) begin
            @(negedge clock);
            k++;
        end
        chk("rst_mid_reached", 32'(g_inst[0].fm_cnt), 32'd19);
        #2 resetb = 1'b0;
        #1;
        chk("rst_mid_csb", 32'(flash_csb[0]), 32'd1);
        chk("rst_mid_sck", 32'(flash_clk[0]), 32'd0);
        chk("rst_mid_io0", 32'(flash_io0[0]), 32'd0);
        chk("rst_mid_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        saw_rsp = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clock);
            if (rsp_valid[0]) saw_rsp++;
        end
        $display("txn reset-abort: rsp pulses after abort=%0d", saw_rsp);
        chk("rst_mid_no_rsp", 32'(saw_rsp), 32'd0);
        do_read(0, 24'h000000, data, lat);
        $display("txn post-reset: addr=0x000000 data=0x%08h latency=%0d", data, lat);
        chk("post_rst_data", data, 32'h3412D500);
        chk("post_rst_latency", 32'(lat), 32'(1 + NBITS * 4));

        repeat (4) @(negedge clock);
        chk("mode0_inst0", 32'(g_inst[0].m0_viol), 32'd0);
        chk("mode0_inst1", 32'(g_inst[1].m0_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Single-bit SPI flash read initiator: the user-project master that drives the external boot flash on mprj_io[8..11] (csb, clk, io0 out, io1 in). It accepts a 24-bit byte address on a valid/ready request port, issues a standard READ (0x03) transaction in SPI mode 0, shifts in one 32-bit little-endian word and returns it on a response port. It sits between the Microwatt boot/fetch path and the pads, and talks to the same flash device model used by the chip-level benches.

## Interface
- CLK_DIV, 2: system clocks per SCK half-period; legal range 1..255.
- CS_IDLE, 4: minimum system clocks flash_csb stays high between transactions; legal range 1..255.
- clock  in  1  system clock; all state updates on its rising edge.
- resetb  in  1  reset, asynchronous, active-low.
- req_valid  in  1  read request present.
- req_ready  out  1  reader can accept a request.
- req_addr  in  24  flash byte address.
- rsp_valid  out  1  one-cycle pulse, rsp_data valid.
- rsp_data  out  32  read word, first flash byte in [7:0].
- busy  out  1  transaction or CS idle gap in progress.
- flash_csb  out  1  chip select, active-low.
- flash_clk  out  1  SPI clock, idles low.
- flash_io0  out  1  MOSI.
- flash_io1  in  1  MISO.

## Operation
- States: IDLE, SHIFT_CMD (8 bits), SHIFT_ADDR (24 bits), [DUMMY (8 cycles)], SHIFT_DATA (32 bits), GAP.
- IDLE: req_ready=1. A request is accepted when req_valid && req_ready; addr is latched, tx shift register loaded with {cmd, addr}, state -> SHIFT_CMD.
- Mode 0: flash_io0 changes only while flash_clk is low; flash_io1 is sampled on the system clock edge where flash_clk goes 0->1. MSB first for command and address.
- Data bits are shifted into a 32-bit register MSB-first per byte; byte k (k=0..3, in arrival order) lands in rsp_data[8k+7:8k].
- After the 32nd data bit's rising SCK edge plus one half-period (SCK back low): flash_csb -> 1, rsp_valid pulses one cycle with rsp_data, state -> GAP.
- GAP: holds CS_IDLE cycles, then IDLE. req_ready low in every state except IDLE.
- flash_io0 drives 0 when not shifting command/address.
- rsp_data holds its value until the next response.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, busy=0, flash_csb=1, flash_clk=0, flash_io0=0; FSM IDLE; counters cleared.
- Accept at cycle edge T: flash_csb=0 and flash_io0=cmd[7] from T+1; first SCK rise at T+1+CLK_DIV.
- Each bit occupies 2*CLK_DIV cycles. Without dummy: 64 bits; rsp_valid at T+1+128*CLK_DIV. With dummy: 72 bits; T+1+144*CLK_DIV.
- Next accept no earlier than CS_IDLE+1 cycles after rsp_valid.
- req_valid during a transfer is ignored (no accept); requester holds req_addr stable only for the accept cycle.
- Address wrap: 0xFFFFFC..0xFFFFFF read is one transaction; wrap to 0 is the flash's behaviour, not the reader's.
- Reset asserted mid-transaction: outputs return to reset values immediately (asynchronously); no rsp_valid is emitted; flash sees CSB rise, aborting the command.

## Configuration
- SPI_FLASH_FAST_READ_EN defined: command 0x0B, DUMMY state inserts 8 SCK cycles (io0 driven 0, io1 ignored) between address and data.
- Undefined: command 0x03, no DUMMY state; the DUMMY state and its counter are not present.

## Structure
- Shared package spi_flash_pkg: state enum, CMD_READ=8'h03, CMD_FAST_READ=8'h0B, CMD_BITS=8, ADDR_BITS=24, DUMMY_BITS=8, DATA_BITS=32.
- One sub-module: spi_sck_gen — half-period counter producing flash_clk plus one-cycle rise/fall strobes; enabled only while flash_csb is low.

## Test plan
- Flash model preloaded 0x000000: 00 D5 12 34; read addr 0x000000 with CLK_DIV=2 -> io0 shows 0x03,0x000000; rsp_data=0x3412D500, rsp_valid at T+257.
- Read addr 0x000101 with CLK_DIV=1 -> flash_clk period 2 cycles, rsp_valid at T+129, data matches model bytes 0x101..0x104.
- Back-to-back req_valid held high -> second accept exactly CS_IDLE+1 cycles after first rsp_valid; flash_csb high ≥CS_IDLE cycles; req_ready low throughout transfer.
- Assert resetb at address bit 10 -> flash_csb=1, flash_clk=0 same cycle, no rsp_valid; next read of 0x000000 returns 0x3412D500.
- SPI_FLASH_FAST_READ_EN build, CLK_DIV=2 -> command 0x0B, 8 dummy clocks, rsp_valid at T+289, data 0x3412D500.
- Mode-0 check: assert io0 never changes while flash_clk=1 and flash_clk=0 whenever flash_csb=1.
